// File: rtl/ack_bus_rr_arbiter_if.sv
// ack_bus_rr_arbiter_if: request/grant/ack-bus bundle between sources and the arbiter
interface ack_bus_rr_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int ID_W = 2
);
  logic ena;
  logic [N_SRC-1:0] req_i;
  logic [N_SRC-1:0] ack_ready_to_o;
  logic [ID_W-1:0] winner_source_id;
  logic ack_event;
  logic ack_valid_n_bus_o;
  logic [ID_W-1:0] ack_id_bus_o;
  logic [N_SRC-1:0] pending_o;
  logic merge_o;
  modport master(
    output ena, req_i,
    input ack_ready_to_o, winner_source_id, ack_event, ack_valid_n_bus_o, ack_id_bus_o, pending_o, merge_o
  );
  modport slave(
    input ena, req_i,
    output ack_ready_to_o, winner_source_id, ack_event, ack_valid_n_bus_o, ack_id_bus_o, pending_o, merge_o
  );
endinterface

// File: rtl/ack_bus_rr_arbiter.sv
// ack_bus_rr_arbiter: round-robin/fixed-priority arbiter driving an active-low ack bus with hold and gap timing
module ack_bus_rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES = 1,
  parameter int FIXED_PRIO = 0
) (
  input logic clk,
  input logic rst_n,
  ack_bus_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ID_W-1:0] rr_q, rr_d, winner_q, winner_d, id_q, id_d, win;
  logic [N_SRC-1:0] pending_q, pending_d, ready_q, ready_d, cand, grant_oh;
  logic valid_n_q, valid_n_d, event_q, event_d, merge_q, merge_d, arb, last;
  int idx;
  always_comb begin
    cand = pending_q | bus.req_i;
    win = '0;
    idx = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (FIXED_PRIO != 0) ? k : (int'(rr_q) + k) % N_SRC;
      if (|(cand & (N_SRC'(1) << idx))) win = ID_W'(idx);
    end
    last = cnt_q == 4'd1;
    arb = bus.ena && (|cand) && (state_q == IDLE || (state_q == GAP && last));
    grant_oh = arb ? N_SRC'(1) << win : '0;
    state_d = arb ? DRIVE : (state_q == DRIVE) ? (last ? GAP : DRIVE) : (state_q == GAP && !last) ? GAP : IDLE;
    cnt_d = arb ? 4'(HOLD_CYCLES) : (state_q == DRIVE) ? (last ? 4'(GAP_CYCLES) : cnt_q - 4'd1) :
            (state_q == GAP && !last) ? cnt_q - 4'd1 : 4'd0;
    winner_d = arb ? win : winner_q;
    rr_d = (arb && FIXED_PRIO == 0) ? ((int'(win) == N_SRC - 1) ? '0 : win + ID_W'(1)) : rr_q;
    pending_d = (pending_q & ~grant_oh) | bus.req_i;
    merge_d = |(bus.req_i & pending_q & ~grant_oh);
    valid_n_d = state_d != DRIVE;
    id_d = valid_n_d ? '0 : winner_d;
    event_d = arb;
    ready_d = (state_d == DRIVE && cnt_d == 4'd1) ? N_SRC'(1) << winner_d : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rr_q <= '0;
      winner_q <= '0;
      id_q <= '0;
      pending_q <= '0;
      ready_q <= '0;
      valid_n_q <= 1'b1;
      event_q <= 1'b0;
      merge_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      winner_q <= winner_d;
      id_q <= id_d;
      pending_q <= pending_d;
      ready_q <= ready_d;
      valid_n_q <= valid_n_d;
      event_q <= event_d;
      merge_q <= merge_d;
    end
  end
  assign bus.ack_ready_to_o = ready_q;
  assign bus.winner_source_id = winner_q;
  assign bus.ack_event = event_q;
  assign bus.ack_valid_n_bus_o = valid_n_q;
  assign bus.ack_id_bus_o = id_q;
  assign bus.pending_o = pending_q;
  assign bus.merge_o = merge_q;
endmodule

// File: tb/tb_ack_bus_rr_arbiter.sv
// tb_ack_bus_rr_arbiter: scoreboard bench for round-robin, fixed-priority and long-hold arbiter variants
module tb_ack_bus_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [3:0] req0 = '0, req1 = '0;
  logic [7:0] req2 = '0;
  int checks = 0, errors = 0, cyc_n = 0;
  int q0[$], q1[$], q2[$];
  int e0, e1, e2 = 0, ev2_cyc = 0, ready2_cnt = 0;
  int b_ids[5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;
  ack_bus_rr_arbiter_if #(.N_SRC(4), .ID_W(2)) b0();
  ack_bus_rr_arbiter_if #(.N_SRC(4), .ID_W(2)) b1();
  ack_bus_rr_arbiter_if #(.N_SRC(8), .ID_W(3)) b2();
  assign b0.ena = ena;
  assign b1.ena = ena;
  assign b2.ena = ena;
  assign b0.req_i = req0;
  assign b1.req_i = req1;
  assign b2.req_i = req2;
  ack_bus_rr_arbiter #(.N_SRC(4), .ID_W(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  ack_bus_rr_arbiter #(.N_SRC(4), .ID_W(2), .FIXED_PRIO(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ack_bus_rr_arbiter #(.N_SRC(8), .ID_W(3), .HOLD_CYCLES(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (b0.ack_event) begin
      e0 = q0.size() != 0 ? q0.pop_front() : -1;
      check("d0_id", 32'(b0.ack_id_bus_o), e0);
      check("d0_winner", 32'(b0.winner_source_id), e0);
      check("d0_valid_n", 32'(b0.ack_valid_n_bus_o), 0);
      check("d0_ready", 32'(b0.ack_ready_to_o), 1 << e0);
    end
    if (b1.ack_event) begin
      e1 = q1.size() != 0 ? q1.pop_front() : -1;
      check("d1_id", 32'(b1.ack_id_bus_o), e1);
      check("d1_ready", 32'(b1.ack_ready_to_o), 1 << e1);
    end
    if (b2.ack_event) begin
      e2 = q2.size() != 0 ? q2.pop_front() : -1;
      ev2_cyc = cyc_n;
      check("d2_id", 32'(b2.ack_id_bus_o), e2);
      check("d2_winner", 32'(b2.winner_source_id), e2);
      check("d2_ready_early", 32'(b2.ack_ready_to_o), 0);
    end
    if (b2.ack_ready_to_o != 0) begin
      ready2_cnt++;
      check("d2_ready", 32'(b2.ack_ready_to_o), 1 << e2);
      check("d2_ready_lat", cyc_n - ev2_cyc, 2);
      check("d2_id_hold", 32'(b2.ack_id_bus_o), e2);
    end
  end
  initial begin
    tick(2);
    check("rst_valid_n", 32'(b0.ack_valid_n_bus_o), 1);
    check("rst_id", 32'(b0.ack_id_bus_o), 0);
    check("rst_winner", 32'(b0.winner_source_id), 0);
    check("rst_event", 32'(b0.ack_event), 0);
    check("rst_ready", 32'(b0.ack_ready_to_o), 0);
    check("rst_pending", 32'(b0.pending_o), 0);
    check("rst_merge", 32'(b0.merge_o), 0);
    check("rst_valid_n2", 32'(b2.ack_valid_n_bus_o), 1);
    rst_n = 1'b1;
    tick();
    req0 = 4'b0100;
    q0.push_back(2);
    q0.push_back(2);
    tick();
    req0 = '0;
    check("a_valid_n", 32'(b0.ack_valid_n_bus_o), 0);
    check("a_id", 32'(b0.ack_id_bus_o), 2);
    check("a_event", 32'(b0.ack_event), 1);
    check("a_ready", 32'(b0.ack_ready_to_o), 4'b0100);
    tick();
    check("a_gap_valid_n", 32'(b0.ack_valid_n_bus_o), 1);
    check("a_gap_id", 32'(b0.ack_id_bus_o), 0);
    check("a_gap_event", 32'(b0.ack_event), 0);
    tick(6);
    do_reset();
    req0 = 4'hf;
    for (int i = 0; i < 5; i++) q0.push_back(b_ids[i]);
    tick();
    req0 = '0;
    for (int i = 0; i < 5; i++) begin
      check("b_event", 32'(b0.ack_event), 1);
      check("b_winner", 32'(b0.winner_source_id), b_ids[i]);
      tick();
      check("b_gap_valid_n", 32'(b0.ack_valid_n_bus_o), 1);
      check("b_gap_winner", 32'(b0.winner_source_id), b_ids[i]);
      tick();
    end
    check("b_idle_event", 32'(b0.ack_event), 0);
    tick(3);
    do_reset();
    ena = 1'b0;
    req0 = 4'b0010;
    tick();
    req0 = '0;
    check("c_merge_first", 32'(b0.merge_o), 0);
    check("c_pending", 32'(b0.pending_o), 4'b0010);
    tick();
    req0 = 4'b0010;
    tick();
    req0 = '0;
    check("c_merge", 32'(b0.merge_o), 1);
    check("c_pending_merged", 32'(b0.pending_o), 4'b0010);
    tick();
    check("c_merge_once", 32'(b0.merge_o), 0);
    q0.push_back(1);
    ena = 1'b1;
    tick();
    check("c_event", 32'(b0.ack_event), 1);
    tick(6);
    check("c_pending_done", 32'(b0.pending_o), 0);
    do_reset();
    ena = 1'b0;
    req0 = 4'b0011;
    tick();
    req0 = '0;
    tick(2);
    check("d_pending", 32'(b0.pending_o), 4'b0011);
    check("d_valid_n", 32'(b0.ack_valid_n_bus_o), 1);
    check("d_event", 32'(b0.ack_event), 0);
    q0.push_back(0);
    q0.push_back(1);
    ena = 1'b1;
    tick();
    check("d_id0", 32'(b0.ack_id_bus_o), 0);
    tick(2);
    check("d_id1", 32'(b0.ack_id_bus_o), 1);
    tick(4);
    do_reset();
    for (int i = 0; i < 8; i++) q1.push_back(0);
    q1.push_back(3);
    q0.push_back(0);
    q0.push_back(3);
    for (int i = 0; i < 6; i++) q0.push_back(0);
    req0 = 4'b1001;
    req1 = 4'b1001;
    tick();
    req0 = '0;
    req1 = '0;
    tick();
    for (int i = 0; i < 6; i++) begin
      req0 = 4'b0001;
      req1 = 4'b0001;
      tick();
      req0 = '0;
      req1 = '0;
      tick();
    end
    tick(10);
    do_reset();
    req2 = 8'h20;
    q2.push_back(5);
    tick();
    req2 = '0;
    check("f_event", 32'(b2.ack_event), 1);
    check("f_id", 32'(b2.ack_id_bus_o), 5);
    tick();
    check("f_drive2_valid_n", 32'(b2.ack_valid_n_bus_o), 0);
    rst_n = 1'b0;
    #1;
    check("f_rst_valid_n", 32'(b2.ack_valid_n_bus_o), 1);
    check("f_rst_id", 32'(b2.ack_id_bus_o), 0);
    check("f_rst_winner", 32'(b2.winner_source_id), 0);
    check("f_rst_event", 32'(b2.ack_event), 0);
    check("f_rst_ready", 32'(b2.ack_ready_to_o), 0);
    check("f_rst_pending", 32'(b2.pending_o), 0);
    check("f_rst_merge", 32'(b2.merge_o), 0);
    tick();
    rst_n = 1'b1;
    tick(3);
    check("f_idle_valid_n", 32'(b2.ack_valid_n_bus_o), 1);
    check("f_no_ready", ready2_cnt, 0);
    req2 = 8'h82;
    q2.push_back(1);
    q2.push_back(7);
    q2.push_back(1);
    tick();
    req2 = '0;
    check("f_first_id", 32'(b2.ack_id_bus_o), 1);
    tick(16);
    check("f_ready_count", ready2_cnt, 3);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
